// File: rtl/cache_mem_controller.sv
// cache_mem_controller: MEM-stage control FSM between a direct-mapped data cache and the SRAM controller
module cache_mem_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_r_en,
  input  logic                mem_w_en,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic                cache_miss,
  input  logic [DATA_W-1:0]   cache_out,
  output logic                cache_fill,
  output logic                cache_inval,
  output logic [2*DATA_W-1:0] fill_data,
  output logic                sram_r_en,
  output logic                sram_w_en,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [2*DATA_W-1:0] sram_rdata,
  input  logic                sram_ready
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE} state_t;
  state_t state, next;
  logic [2*DATA_W-1:0] line_buf;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // line buffer holds the fetched block until the word is returned in RD_DONE
  always_ff @(posedge clk or posedge rst)
    if (rst) line_buf <= '0;
    else if (state == RD_WAIT && sram_ready) line_buf <= sram_rdata;
  // next-state logic; stores take priority over loads
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = mem_w_en ? WR_WAIT : (mem_r_en && cache_miss) ? RD_WAIT : IDLE;
      RD_WAIT: next = sram_ready ? RD_DONE : RD_WAIT;
      WR_WAIT: next = sram_ready ? WR_DONE : WR_WAIT;
      default: next = IDLE;
    endcase
  end
  // outputs; reset forces the idle values so strobes drop the instant rst rises
  always_comb begin
    ready       = 1'b1;
    rdata       = '0;
    cache_fill  = 1'b0;
    cache_inval = 1'b0;
    sram_r_en   = 1'b0;
    sram_w_en   = 1'b0;
    fill_data   = line_buf;
    if (!rst)
      case (state)
        IDLE: begin
          sram_w_en   = mem_w_en;
          cache_inval = mem_w_en && !cache_miss;
          sram_r_en   = !mem_w_en && mem_r_en && cache_miss;
          ready       = !(mem_w_en || (mem_r_en && cache_miss));
          rdata       = (mem_r_en && !mem_w_en && !cache_miss) ? cache_out : '0;
        end
        RD_WAIT: begin
          sram_r_en  = 1'b1;
          ready      = 1'b0;
          cache_fill = sram_ready;
          fill_data  = sram_ready ? sram_rdata : line_buf;
        end
        RD_DONE: rdata = address[2] ? line_buf[2*DATA_W-1:DATA_W] : line_buf[DATA_W-1:0];
        WR_WAIT: begin
          sram_w_en = 1'b1;
          ready     = 1'b0;
        end
        default: ready = 1'b1;
      endcase
  end
  assign sram_addr  = (sram_r_en || sram_w_en) ? address : '0;
  assign sram_wdata = sram_w_en ? wdata : '0;
endmodule

// File: tb/tb_cache_mem_controller.sv
// tb_cache_mem_controller: random and directed checks against a cache/SRAM reference model
module tb_cache_mem_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata, rdata, cache_out, sram_addr, sram_wdata;
  logic        ready, cache_miss, cache_fill, cache_inval, sram_r_en, sram_w_en, sram_ready;
  logic [63:0] fill_data, sram_rdata;
  int total = 0;
  int passed = 0;
  logic        c_v [64];
  logic [22:0] c_t [64];
  logic [63:0] c_d [64];
  logic [31:0] mem [int unsigned];

  cache_mem_controller dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .address(address),
    .wdata(wdata), .rdata(rdata), .ready(ready), .cache_miss(cache_miss), .cache_out(cache_out),
    .cache_fill(cache_fill), .cache_inval(cache_inval), .fill_data(fill_data),
    .sram_r_en(sram_r_en), .sram_w_en(sram_w_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ((a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A);
  endfunction

  function automatic logic [63:0] blk(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:3], 3'b000};
    return {mrd(b + 32'd4), mrd(b)};
  endfunction

  function automatic bit hit(input logic [31:0] a);
    return c_v[a[8:3]] && c_t[a[8:3]] == a[31:9];
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    cache_miss = !hit(address);
    cache_out  = address[2] ? c_d[address[8:3]][63:32] : c_d[address[8:3]][31:0];
    #4;
  endtask

  task automatic op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd, input int lat);
    bit h;
    logic [63:0] b;
    cyc();
    mem_w_en = wr; mem_r_en = rd; address = a; wdata = wd; sram_ready = 1'b0;
    settle();
    h = hit(a);
    b = blk(a);
    if (rd && !wr && h) begin
      chk("hit_ready", 64'(ready), 64'(1));
      chk("hit_rdata", 64'(rdata), 64'(mrd(a)));
      chk("hit_strobes", 64'({sram_r_en, sram_w_en, cache_fill, cache_inval}), 64'(0));
      return;
    end
    chk("req_ready", 64'(ready), 64'(0));
    chk("req_strobes", 64'({sram_r_en, sram_w_en, cache_fill}), wr ? 64'b010 : 64'b100);
    chk("req_inval", 64'(cache_inval), 64'(wr && h));
    chk("req_addr", 64'(sram_addr), 64'(a));
    if (wr) begin
      chk("req_wdata", 64'(sram_wdata), 64'(wd));
      if (h) c_v[a[8:3]] = 1'b0;
    end
    for (int k = 2; k <= lat; k++) begin
      cyc();
      sram_ready = (k == lat);
      sram_rdata = (k == lat && !wr) ? b : {$urandom, $urandom};
      settle();
      chk("wait_ready", 64'(ready), 64'(0));
      chk("wait_strobes", 64'({sram_r_en, sram_w_en, cache_inval}), wr ? 64'b010 : 64'b100);
      chk("wait_fill", 64'(cache_fill), 64'(!wr && k == lat));
      if (!wr && k == lat) begin
        chk("fill_data", fill_data, b);
        c_v[a[8:3]] = 1'b1;
        c_t[a[8:3]] = a[31:9];
        c_d[a[8:3]] = b;
      end
    end
    cyc();
    sram_ready = 1'b0;
    settle();
    chk("done_ready", 64'(ready), 64'(1));
    chk("done_strobes", 64'({sram_r_en, sram_w_en, cache_fill, cache_inval}), 64'(0));
    if (wr) mem[a] = wd;
    else chk("done_rdata", 64'(rdata), 64'(mrd(a)));
  endtask

  task automatic idle_spur();
    for (int k = 0; k < 2; k++) begin
      cyc();
      mem_r_en = 1'b0; mem_w_en = 1'b0;
      sram_ready = (k == 0);
      sram_rdata = {$urandom, $urandom};
      settle();
      chk("spur_ready", 64'(ready), 64'(1));
      chk("spur_strobes", 64'({sram_r_en, sram_w_en, cache_fill, cache_inval}), 64'(0));
      chk("spur_rdata", 64'(rdata), 64'(0));
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      c_v[i] = 1'b0; c_t[i] = '0; c_d[i] = '0;
    end
    mem[32'h10] = 32'hAAAA_AAAA;
    mem[32'h14] = 32'hBBBB_BBBB;
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; wdata = '0;
    cache_miss = 1'b1; cache_out = '0; sram_rdata = '0; sram_ready = 1'b0;
    #2;
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_strobes", 64'({sram_r_en, sram_w_en, cache_fill, cache_inval}), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_fill_data", fill_data, 64'(0));
    cyc();
    rst = 1'b0;
    op(1'b0, 1'b1, 32'h10, 32'h0, 5);
    op(1'b0, 1'b1, 32'h14, 32'h0, 3);
    op(1'b1, 1'b0, 32'h10, 32'h1234_5678, 3);
    op(1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 4);
    cyc();
    mem_r_en = 1'b1; mem_w_en = 1'b0; address = 32'h40; sram_ready = 1'b0;
    settle();
    chk("rstmid_req", 64'(sram_r_en), 64'(1));
    for (int k = 0; k < 3; k++) begin
      cyc();
      settle();
    end
    rst = 1'b1;
    #1;
    chk("rstmid_sram_r_en", 64'(sram_r_en), 64'(0));
    chk("rstmid_ready", 64'(ready), 64'(1));
    chk("rstmid_fill", 64'({cache_fill, fill_data}), 64'(0));
    cyc();
    mem_r_en = 1'b0; sram_ready = 1'b1; sram_rdata = {$urandom, $urandom};
    settle();
    chk("rstmid_nofill", 64'(cache_fill), 64'(0));
    cyc();
    rst = 1'b0; sram_ready = 1'b0;
    settle();
    chk("rstmid_idle", 64'({ready, sram_r_en, sram_w_en, cache_fill, cache_inval}), 64'b10000);
    op(1'b0, 1'b1, 32'h40, 32'h0, 3);
    idle_spur();
    for (int n = 0; n < 120; n++) begin
      int sel;
      logic [31:0] a;
      sel = int'($urandom_range(0, 99));
      a = 32'($urandom_range(0, 511)) << 2;
      if (sel < 50) op(1'b0, 1'b1, a, 32'h0, int'($urandom_range(2, 6)));
      else if (sel < 80) op(1'b1, 1'b0, a, $urandom, int'($urandom_range(2, 6)));
      else if (sel < 90) op(1'b1, 1'b1, a, $urandom, int'($urandom_range(2, 6)));
      else idle_spur();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
